imem_arbiter: RTL



---
 rtl/imem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory owner: boot loader, fetch and debug read sequencing
// The debug read port and its starve counter exist only when IMEM_ARB_DEBUG_EN is defined.
module imem_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 22,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_stall,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic              boot_done,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_PAUSE1 = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              fetch_pend_q, fetch_pend_d;
  logic [DATA_W-1:0] fetch_hold_q, fetch_hold_d;
  logic              run;
  logic              dbg_grant;
  logic [ADDR_W-3:0] dbg_word;
  logic              unused;

  assign run = (state_q == ST_RUN);

`ifdef IMEM_ARB_DEBUG_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;
  logic       dbg_inflight_q, dbg_inflight_d;

  // The cycle after a grant is its ack cycle, where the same request is still
  // high; only the starve limit can open a new grant.
  always_comb begin
    dbg_grant      = run && dbg_req && !dbg_inflight_q && (starve_q == LIMIT);
    dbg_inflight_d = dbg_grant;
    starve_d       = starve_q;
    if (!run || !dbg_req || dbg_grant) begin
      starve_d = '0;
    end else if (!dbg_inflight_q && (starve_q != LIMIT)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q       <= '0;
      dbg_inflight_q <= 1'b0;
    end else begin
      starve_q       <= starve_d;
      dbg_inflight_q <= dbg_inflight_d;
    end
  end

  // A reset arriving in the ack cycle drops the read without acknowledging it.
  assign dbg_ack  = dbg_inflight_q && !rst;
  assign dbg_data = dbg_ack ? mem_rdata : '0;
  assign dbg_word = dbg_addr[ADDR_W-1:2];
  assign unused   = ^{fetch_addr[1:0], ld_addr[1:0], dbg_addr[1:0]};
`else
  assign dbg_grant = 1'b0;
  assign dbg_ack   = 1'b0;
  assign dbg_data  = '0;
  assign dbg_word  = '0;
  assign unused    = ^{fetch_addr[1:0], ld_addr[1:0], dbg_req, dbg_addr};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   if (ld_done && !ld_valid) state_d = ST_PAUSE1;
      ST_PAUSE1: state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    mem_addr     = fetch_addr[ADDR_W-1:2];
    mem_we       = 1'b0;
    mem_wdata    = ld_data;
    fetch_stall  = 1'b1;
    ld_ready     = 1'b0;
    boot_done    = 1'b0;
    fetch_pend_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ld_ready = 1'b1;
        mem_we   = ld_valid;
        mem_addr = ld_addr[ADDR_W-1:2];
      end
      ST_RUN: begin
        boot_done = 1'b1;
        if (dbg_grant) begin
          mem_addr = dbg_word;
        end else begin
          fetch_stall  = 1'b0;
          fetch_pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Fetch data passes straight from the memory in the cycle after a fetch
  // grant and is held across stalled cycles.
  assign fetch_data   = fetch_pend_q ? mem_rdata : fetch_hold_q;
  assign fetch_hold_d = fetch_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      fetch_pend_q <= 1'b0;
      fetch_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
      fetch_hold_q <= fetch_hold_d;
    end
  end

endmodule
